// File: rtl/cache_refill_ctrl.sv
// Miss-handling sequencer for the 4-way L1: writes back a dirty victim, reads the
// missing line from memory and returns it to the cache as one fill beat.
module cache_refill_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 512,
  parameter int OFFSET_BITS = 6,
  parameter int INDEX_BITS  = 7,
  parameter int TIMEOUT     = 255
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     miss_valid,
  output logic                                     miss_ready,
  input  logic [ADDR_W-1:0]                        miss_addr,
  input  logic [1:0]                               victim_way,
  input  logic                                     victim_dirty,
  input  logic [ADDR_W-INDEX_BITS-OFFSET_BITS-1:0] victim_tag,
  input  logic [LINE_W-1:0]                        victim_data,
  output logic                                     mem_req,
  output logic                                     mem_we,
  output logic [ADDR_W-1:0]                        mem_addr,
  output logic [LINE_W-1:0]                        mem_wdata,
  input  logic                                     mem_ack,
  input  logic [LINE_W-1:0]                        mem_rdata,
  output logic                                     fill_valid,
  output logic [1:0]                               fill_way,
  output logic [ADDR_W-1:0]                        fill_addr,
  output logic [LINE_W-1:0]                        fill_data,
  output logic                                     err,
  output logic                                     busy,
  output logic [15:0]                              miss_count,
  output logic [15:0]                              wb_count
);
  localparam int TAG_W = ADDR_W - INDEX_BITS - OFFSET_BITS;
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFFSET_BITS) - 64'd1);

  typedef enum logic [1:0] {IDLE, WB, RD, FILL} state_e;
  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        way_q, way_d;
  logic [TAG_W-1:0]  vtag_q, vtag_d;
  logic [LINE_W-1:0] vdata_q, vdata_d;
  logic [7:0]        wait_q, wait_d;
  logic              req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              fvalid_q, fvalid_d;
  logic [1:0]        fway_q, fway_d;
  logic [ADDR_W-1:0] faddr_q, faddr_d;
  logic [LINE_W-1:0] fdata_q, fdata_d;
  logic              err_q, err_d, ready_q, ready_d;
  logic [15:0]       miss_count_q, miss_count_d, wb_count_q, wb_count_d;

  logic              accept, ack_ok, waiting, to_hit;
  logic [7:0]        wait_inc;
  logic [ADDR_W-1:0] rd_addr, wb_addr;

  // An ack only counts while a request is actually outstanding.
  assign accept   = miss_valid && ready_q;
  assign ack_ok   = mem_ack && req_q;
  assign waiting  = req_q && !mem_ack;
  assign wait_inc = wait_q + 8'd1;
  assign to_hit   = waiting && (wait_inc == TO_LIM);
  assign rd_addr  = addr_q;
  assign wb_addr  = {vtag_q, addr_q[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS], OFFSET_BITS'(0)};

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = victim_dirty ? WB : RD;
      WB:      if (ack_ok) state_d = RD;   else if (to_hit) state_d = IDLE;
      RD:      if (ack_ok) state_d = FILL; else if (to_hit) state_d = IDLE;
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    way_d   = way_q;
    vtag_d  = vtag_q;
    vdata_d = vdata_q;
    if (state_q == IDLE && accept) begin
      addr_d  = miss_addr & ~OFF_MASK;
      way_d   = victim_way;
      vtag_d  = victim_tag;
      vdata_d = victim_data;
    end
    // The request stays up across WB->RD so memory sees one continuous req.
    req_d   = (state_q == WB || state_q == RD) && !to_hit && !(state_q == RD && ack_ok);
    we_d    = (state_q == WB) && !ack_ok && !to_hit;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    if (state_q == WB && !ack_ok) begin
      maddr_d = wb_addr;
      wdata_d = vdata_q;
    end else if (state_q == WB || state_q == RD) begin
      maddr_d = rd_addr;
    end
    wait_d = wait_q;
    if (state_q == IDLE || state_q == FILL || ack_ok) wait_d = 8'd0;
    else if (waiting)                                 wait_d = wait_inc;
    fvalid_d = (state_q == RD) && ack_ok;
    fway_d   = fway_q;
    faddr_d  = faddr_q;
    fdata_d  = fdata_q;
    if (fvalid_d) begin
      fway_d  = way_q;
      faddr_d = rd_addr;
      fdata_d = mem_rdata;
    end
    err_d        = to_hit;
    ready_d      = (state_d == IDLE);
    miss_count_d = miss_count_q + 16'(accept);
    wb_count_d   = wb_count_q + 16'((state_q == WB) && ack_ok);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q       <= '0;
      way_q        <= '0;
      vtag_q       <= '0;
      vdata_q      <= '0;
      wait_q       <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      maddr_q      <= '0;
      wdata_q      <= '0;
      fvalid_q     <= 1'b0;
      fway_q       <= '0;
      faddr_q      <= '0;
      fdata_q      <= '0;
      err_q        <= 1'b0;
      ready_q      <= 1'b0;
      miss_count_q <= '0;
      wb_count_q   <= '0;
    end else begin
      addr_q       <= addr_d;
      way_q        <= way_d;
      vtag_q       <= vtag_d;
      vdata_q      <= vdata_d;
      wait_q       <= wait_d;
      req_q        <= req_d;
      we_q         <= we_d;
      maddr_q      <= maddr_d;
      wdata_q      <= wdata_d;
      fvalid_q     <= fvalid_d;
      fway_q       <= fway_d;
      faddr_q      <= faddr_d;
      fdata_q      <= fdata_d;
      err_q        <= err_d;
      ready_q      <= ready_d;
      miss_count_q <= miss_count_d;
      wb_count_q   <= wb_count_d;
    end
  end

  assign miss_ready = ready_q;
  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = maddr_q;
  assign mem_wdata  = wdata_q;
  assign fill_valid = fvalid_q;
  assign fill_way   = fway_q;
  assign fill_addr  = faddr_q;
  assign fill_data  = fdata_q;
  assign err        = err_q;
  assign busy       = (state_q != IDLE);
  assign miss_count = miss_count_q;
  assign wb_count   = wb_count_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: reset, clean/dirty refill, timeout,
// reset during writeback, counter wrap with back-to-back misses.
module tb_cache_refill_ctrl;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 512;
  localparam int TAG_W  = 19;

  localparam logic [LINE_W-1:0] PAT_A  = {16{32'hA5A5_0001}};
  localparam logic [LINE_W-1:0] PAT_B  = {16{32'h5A5A_0002}};
  localparam logic [LINE_W-1:0] PAT_VD = {16{32'hDEAD_BEEF}};
  localparam logic [LINE_W-1:0] PAT_X  = {16{32'h0F0F_3C3C}};

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              miss_valid = 1'b0;
  logic              miss_ready;
  logic [ADDR_W-1:0] miss_addr = '0;
  logic [1:0]        victim_way = '0;
  logic              victim_dirty = 1'b0;
  logic [TAG_W-1:0]  victim_tag = '0;
  logic [LINE_W-1:0] victim_data = '0;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_ack = 1'b0;
  logic [LINE_W-1:0] mem_rdata = '0;
  logic              fill_valid;
  logic [1:0]        fill_way;
  logic [ADDR_W-1:0] fill_addr;
  logic [LINE_W-1:0] fill_data;
  logic              err, busy;
  logic [15:0]       miss_count, wb_count;

  int n_cmp = 0;
  int n_err = 0;

  cache_refill_ctrl #(
    .ADDR_W(ADDR_W), .LINE_W(LINE_W), .OFFSET_BITS(6), .INDEX_BITS(7), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .victim_way(victim_way), .victim_dirty(victim_dirty), .victim_tag(victim_tag),
    .victim_data(victim_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .fill_valid(fill_valid), .fill_way(fill_way), .fill_addr(fill_addr), .fill_data(fill_data),
    .err(err), .busy(busy), .miss_count(miss_count), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic issue(input logic [ADDR_W-1:0] a, input logic [1:0] w, input logic d,
                       input logic [TAG_W-1:0] t, input logic [LINE_W-1:0] v);
    miss_valid   = 1'b1;
    miss_addr    = a;
    victim_way   = w;
    victim_dirty = d;
    victim_tag   = t;
    victim_data  = v;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with a pending miss request
    issue(32'h0000_1A7F, 2'd2, 1'b0, 19'h00003, PAT_X);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rst_miss_ready", miss_ready, 0);
    end
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_fill_valid", fill_valid, 0);
    chk("rst_fill_way", fill_way, 0);
    chk("rst_fill_addr", fill_addr, 0);
    chk("rst_fill_data", fill_data, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_miss_count", miss_count, 0);
    chk("rst_wb_count", wb_count, 0);
    rst = 1'b1;
    miss_valid = 1'b0;
    tick;
    chk("post_rst_miss_ready", miss_ready, 1);
    chk("post_rst_miss_count", miss_count, 0);

    // Clean miss, ack on the 4th request cycle
    issue(32'h0000_1A7F, 2'd2, 1'b0, 19'h00003, PAT_X);
    tick;
    miss_valid = 1'b0;
    chk("clean_busy", busy, 1);
    chk("clean_ready_low", miss_ready, 0);
    chk("clean_req_delay", mem_req, 0);
    chk("clean_miss_count", miss_count, 1);
    tick;
    chk("clean_req", mem_req, 1);
    chk("clean_we", mem_we, 0);
    chk("clean_addr", mem_addr, 32'h0000_1A40);
    tick;
    tick;
    tick;
    chk("clean_req_held", mem_req, 1);
    mem_ack = 1'b1;
    mem_rdata = PAT_A;
    tick;
    mem_ack = 1'b0;
    chk("clean_fill_valid", fill_valid, 1);
    chk("clean_fill_way", fill_way, 2);
    chk("clean_fill_addr", fill_addr, 32'h0000_1A40);
    chk("clean_fill_data", fill_data, PAT_A);
    chk("clean_req_drop", mem_req, 0);
    tick;
    chk("clean_fill_pulse", fill_valid, 0);
    chk("clean_ready_back", miss_ready, 1);
    chk("clean_idle", busy, 0);
    chk("clean_wb_count", wb_count, 0);

    // Dirty miss with inputs disturbed mid-transaction
    issue(32'h0004_1A55, 2'd1, 1'b1, 19'h00005, PAT_VD);
    tick;
    issue(32'hFFFF_FFFF, 2'd0, 1'b0, 19'h7FFFF, PAT_X);
    tick;
    chk("dirty_req", mem_req, 1);
    chk("dirty_we", mem_we, 1);
    chk("dirty_wb_addr", mem_addr, 32'h0000_BA40);
    chk("dirty_wdata", mem_wdata, PAT_VD);
    tick;
    chk("dirty_req_held", mem_req, 1);
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    chk("dirty_req_cont", mem_req, 1);
    chk("dirty_we_fall", mem_we, 0);
    chk("dirty_rd_addr", mem_addr, 32'h0004_1A40);
    chk("dirty_wb_count", wb_count, 1);
    mem_ack = 1'b1;
    mem_rdata = PAT_B;
    tick;
    mem_ack = 1'b0;
    miss_valid = 1'b0;
    chk("dirty_fill_valid", fill_valid, 1);
    chk("dirty_fill_way", fill_way, 1);
    chk("dirty_fill_addr", fill_addr, 32'h0004_1A40);
    chk("dirty_fill_data", fill_data, PAT_B);
    chk("dirty_miss_count", miss_count, 2);
    tick;
    chk("dirty_idle", busy, 0);

    // Timeout: no ack ever arrives
    issue(32'h0000_2000, 2'd3, 1'b0, 19'h00001, PAT_X);
    tick;
    miss_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      chk($sformatf("to_req_%0d", i), mem_req, 1);
    end
    tick;
    chk("to_err", err, 1);
    chk("to_req_low", mem_req, 0);
    chk("to_no_fill", fill_valid, 0);
    chk("to_idle", busy, 0);
    chk("to_wb_count", wb_count, 1);
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    chk("to_err_pulse", err, 0);
    chk("spur_fill", fill_valid, 0);
    chk("spur_busy", busy, 0);
    chk("spur_wb_count", wb_count, 1);
    chk("spur_miss_count", miss_count, 3);

    // Reset while a writeback is outstanding, then a late ack
    issue(32'h0004_1A55, 2'd1, 1'b1, 19'h00005, PAT_VD);
    tick;
    miss_valid = 1'b0;
    tick;
    chk("rmw_req", mem_req, 1);
    rst = 1'b0;
    tick;
    chk("rmw_req_low", mem_req, 0);
    chk("rmw_we_low", mem_we, 0);
    chk("rmw_addr", mem_addr, 0);
    chk("rmw_wdata", mem_wdata, 0);
    chk("rmw_busy", busy, 0);
    chk("rmw_miss_count", miss_count, 0);
    chk("rmw_wb_count", wb_count, 0);
    rst = 1'b1;
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    chk("late_ack_wb", wb_count, 0);
    chk("late_ack_fill", fill_valid, 0);
    chk("late_ack_req", mem_req, 0);
    chk("late_ack_ready", miss_ready, 1);

    // Counter wrap with back-to-back misses
    force dut.miss_count_q = 16'hFFFE;
    tick;
    release dut.miss_count_q;
    tick;
    chk("wrap_preset", miss_count, 16'hFFFE);
    issue(32'h0001_0040, 2'd0, 1'b0, 19'h00008, PAT_X);
    for (int i = 0; i < 4; i++) begin
      logic [15:0]       exp_cnt;
      logic [LINE_W-1:0] pat;
      exp_cnt = 16'hFFFF + 16'(i);
      pat     = {16{32'h1000_0000 + 32'(i)}};
      tick;
      chk($sformatf("b2b_busy_%0d", i), busy, 1);
      chk($sformatf("b2b_count_%0d", i), miss_count, exp_cnt);
      tick;
      chk($sformatf("b2b_req_%0d", i), mem_req, 1);
      mem_ack = 1'b1;
      mem_rdata = pat;
      tick;
      mem_ack = 1'b0;
      chk($sformatf("b2b_fill_%0d", i), fill_valid, 1);
      chk($sformatf("b2b_data_%0d", i), fill_data, pat);
      tick;
      chk($sformatf("b2b_ready_%0d", i), miss_ready, 1);
      if (i == 3) miss_valid = 1'b0;
    end
    tick;
    chk("b2b_final_idle", busy, 0);
    chk("b2b_final_count", miss_count, 16'h0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Miss-handling sequencer for the 4-way set-associative L1 cache (128 sets, 64-byte lines, 32-bit address split into tag[31:13] / index[12:6] / offset[5:0]). On a miss reported by the cache datapath, it writes back the dirty victim line to main memory, fetches the missing line, and hands it back to the cache as a single fill beat. It sits between the cache datapath/FSM and the main-memory port. It owns the memory request handshake, a per-transaction ack timeout, and the miss/writeback statistics counters.

## Interface
- ADDR_W, 32, byte address width
- LINE_W, 512, cache line width in bits
- OFFSET_BITS, 6, line offset bits; forced to zero on every memory address
- INDEX_BITS, 7, set index bits
- TIMEOUT, 255, maximum cycles to wait for mem_ack per memory transaction (8-bit counter)
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- miss_valid  in  1  cache requests a refill
- miss_ready  out  1  high only in IDLE; the request is accepted on miss_valid & miss_ready
- miss_addr  in  ADDR_W  missing byte address
- victim_way  in  2  way chosen by LRU for replacement
- victim_dirty  in  1  victim must be written back first
- victim_tag  in  ADDR_W-INDEX_BITS-OFFSET_BITS  victim tag
- victim_data  in  LINE_W  victim line contents
- mem_req  out  1  memory request, held until ack or timeout
- mem_we  out  1  1 = writeback, 0 = line read
- mem_addr  out  ADDR_W  line-aligned address
- mem_wdata  out  LINE_W  writeback data
- mem_ack  in  1  one-cycle acknowledge; mem_rdata is valid with it on reads
- mem_rdata  in  LINE_W  read line
- fill_valid  out  1  one-cycle pulse: write the line into the cache
- fill_way  out  2  target way
- fill_addr  out  ADDR_W  line-aligned address of the filled line
- fill_data  out  LINE_W  line data
- err  out  1  one-cycle pulse on timeout
- busy  out  1  state != IDLE
- miss_count  out  16  accepted misses, wrapping
- wb_count  out  16  completed writebacks, wrapping

## Operation
- States: IDLE, WB, RD, FILL.
- IDLE: on accept, register miss_addr (offset zeroed), victim_way, victim_dirty, victim_tag, victim_data; miss_count += 1. Go to WB if victim_dirty, else to RD.
- WB: mem_req=1, mem_we=1, mem_addr={victim_tag, index, 0}, mem_wdata=victim line. On mem_ack: wb_count += 1, go to RD.
- RD: mem_req=1, mem_we=0, mem_addr={tag, index, 0}. On mem_ack: latch mem_rdata, go to FILL.
- FILL: fill_valid=1 with fill_way, fill_addr, fill_data. Go to IDLE.
- Timeout: the wait counter clears on entry to WB or RD and increments each cycle mem_req is high without mem_ack. When it reaches TIMEOUT with no ack: err=1, mem_req drops, go to IDLE. No fill occurs, and wb_count is not incremented.
- mem_ack is ignored whenever mem_req is low (IDLE, FILL, reset).
- miss_valid is ignored outside IDLE. Captured request fields remain stable for the whole transaction regardless of input changes.
- Counters wrap from 0xFFFF to 0x0000.
- Reset (rst=0 at an edge), including mid-transaction: state=IDLE. The following outputs are 0: mem_req, mem_we, fill_valid, err, busy, miss_count, wb_count, mem_addr, mem_wdata, fill_way, fill_addr, fill_data. miss_ready=1 starting from the first edge with rst=1 after reset. A pending memory transaction is abandoned; a late ack is ignored.

## Timing
- Outputs are registered from state; mem_req asserts the cycle after the transition into WB or RD.
- Clean miss accepted at edge T: mem_req high in T+1. Earliest mem_ack is sampled at edge T+2, giving fill_valid in cycle T+2→T+3 and miss_ready high again one cycle later. Minimum occupancy is 3 cycles.
- Dirty miss: +1 cycle plus the writeback ack latency. mem_we falls and mem_addr switches to the read address in the cycle after the writeback ack; mem_req stays high across the WB→RD transition.
- A back-to-back miss can be accepted in the cycle after the fill_valid pulse.
- Timeout: err pulses in the cycle after the counter reaches TIMEOUT, and mem_req is low in that same cycle.

## Test plan
- Reset: hold rst=0 for 3 cycles with miss_valid=1 -> all outputs 0, no request accepted; miss_ready=1 after release.
- Clean miss: miss_addr=0x0000_1A7F, victim_way=2, victim_dirty=0, ack after 4 cycles with rdata=pattern A -> single read at mem_addr 0x0000_1A40, fill_way=2, fill_data=A, miss_count=1, wb_count=0.
- Dirty miss: victim_tag=0x00005, index=0x69, victim_dirty=1 -> writeback to 0x0000_BA40 with victim_data, then read, then fill; wb_count=1, mem_req continuous across the switch.
- Timeout: TIMEOUT=8, never ack -> err pulse after 8 waiting cycles, no fill_valid, back in IDLE; a subsequent spurious mem_ack has no effect.
- Reset mid-writeback: rst=0 while mem_req=1 -> mem_req=0 next cycle, counters 0; a late ack is ignored.
- Counter wrap and back-to-back: 65537 clean misses -> miss_count=1; each new accept occurs the cycle after the previous fill.
